video_pattern_gen: RTL and testbench
====================================

Name: video_pattern_gen

Overview:
- Parametrised successor to the fixed 640x480 test source feeding the llhdmi encoder on the ULX3S HDMI path.
- Pulls pixels through the encoder's rd/newline/newframe handshake.
- Selects one of five run-time patterns, latched per frame.
- Tracks x/y position with saturation and reports handshake overruns.

Parameters:
- H_ACTIVE, 640, active pixels per line (must be a multiple of 8).
- V_ACTIVE, 480, active lines per frame.
- BITS_PER_COLOR, 8, bits per colour channel.
- CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels.
- GRAD_SHIFT, 2, gradient level = x >> GRAD_SHIFT, truncated to BITS_PER_COLOR.

Ports:
- clk_25mhz  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- i_rd  in  1  consumer takes o_pixel this cycle.
- i_newline  in  1  start of next line.
- i_newframe  in  1  start of frame.
- i_mode  in  3  requested pattern, sampled only on i_newframe.
- i_solid  in  3*BITS_PER_COLOR  colour used by mode 3.
- o_pixel  out  3*BITS_PER_COLOR  {red,grn,blu} for the current (x,y).
- o_mode  out  3  pattern currently displayed.
- o_overrun  out  1  sticky: i_rd or i_newline arrived past the active area.
- o_frame_count  out  16  frames started (optional feature only).

Behaviour:
Reset state:
- x=0, y=0, o_mode=0, o_overrun=0, o_frame_count=0.
- o_pixel = colour bar 0 (white).

Position counters:
- i_newframe: x<=0, y<=0, o_mode<=i_mode, o_overrun<=0.
- i_newline: x<=0, y<=y+1. At y==V_ACTIVE-1, y holds and o_overrun<=1.
- i_rd: x<=x+1. At x==H_ACTIVE-1, x holds and o_overrun<=1.
- Priority: i_newframe > i_newline > i_rd. A lower-priority strobe in the same cycle is ignored and does not set overrun.

Pixel output:
- o_pixel is registered and always shows the pixel for the current (x,y).
- Consumer samples o_pixel in the cycle it asserts i_rd; the next pixel appears the following cycle.
- Consecutive i_rd every cycle must be sustained (no bubbles).

Modes:
- 0 colour bars: 8 bars of width BAR_W=H_ACTIVE/8. Order: white, yellow, cyan, green, magenta, red, blue, black; full scale = all ones. Bar index comes from a sub-counter plus bar counter, with no divider.
- 1 grey gradient: R=G=B=(x>>GRAD_SHIFT)[BITS_PER_COLOR-1:0].
- 2 checkerboard: white if x[CHECK_LOG2]^y[CHECK_LOG2], else black.
- 3 solid: i_solid. Sampled live, not latched.
- 4 border: white where x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1; else black.
- 5-7: black; o_mode still reports the latched value.

Mode switching:
- A mode change without i_newframe has no effect.
- Reset mid-frame returns to the reset state; the next i_newframe resumes normally.

Optional Feature:
Macro PATTERN_SCROLL_EN.
- Defined:
  - o_frame_count increments on every i_newframe and wraps at 16 bits.
  - Modes 0 and 2 use xs = (x + o_frame_count) mod H_ACTIVE in place of x, so the pattern scrolls left one pixel per frame. Bar sub-counters are preloaded accordingly at each line start.
- Undefined:
  - No frame counter; o_frame_count tied to 0.
  - Patterns are static.

Decomposition:
- Shared package video_pkg:
  - mode encodings MODE_BARS=0, MODE_GRAD=1, MODE_CHECK=2, MODE_SOLID=3, MODE_BORDER=4.
  - 8-entry bar colour table as 3-bit RGB masks, expanded to BITS_PER_COLOR.
  - localparam helpers for BAR_W.
- Sub-module video_pos_counter: x/y counters with priority, saturation, overrun flag and bar sub-counter. Pattern muxing stays in the top.

Test Plan (H_ACTIVE=640, V_ACTIVE=480, BITS_PER_COLOR=8):
- Reset, then i_newframe with i_mode=0, then 640 consecutive i_rd → pixels 0-79 = FFFFFF, 80-159 = FFFF00, …, 560-639 = 000000; o_overrun=0.
- Mode 1, GRAD_SHIFT=2 → pixel at x=4 is 010101, x=1023/4-equivalent x=636 is 9F9F9F; mode 2 at (32,0) = FFFFFF, (32,32) = 000000.
- i_newframe with i_mode=3 and i_solid=123456, then change i_mode to 0 mid-frame → output stays 123456 until the next i_newframe, then bars.
- 641st i_rd on a line, or 480th i_newline → x holds at 639 / y holds at 479, o_overrun=1; cleared by the next i_newframe.
- i_newframe, i_newline and i_rd asserted in the same cycle → x=0, y=0, overrun unchanged (0); i_rd every cycle produces no bubbles.
- PATTERN_SCROLL_EN defined: after 3 i_newframe, o_frame_count=3 and bar 1 starts at x=77; without the macro, o_frame_count=0 and the bar boundary stays at x=80.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the video pattern generator: mode encodings,
// the colour-bar table and bar-width helper.
package video_pkg;

  typedef enum logic [2:0] {
    MODE_BARS   = 3'd0,
    MODE_GRAD   = 3'd1,
    MODE_CHECK  = 3'd2,
    MODE_SOLID  = 3'd3,
    MODE_BORDER = 3'd4
  } mode_e;

  localparam int NUM_BARS = 8;

  // {red,grn,blu} masks: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_RGB [NUM_BARS] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  function automatic int bar_w(input int h_active);
    return h_active / NUM_BARS;
  endfunction

  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    return BAR_RGB[idx];
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Pixel-pull handshake between the HDMI encoder (master) and the
// pattern generator (slave). Signal prefixes are from the generator's view.
interface video_pattern_gen_if #(
  parameter int BITS_PER_COLOR = 8
);
  logic                          i_rd;
  logic                          i_newline;
  logic                          i_newframe;
  logic [2:0]                    i_mode;
  logic [3*BITS_PER_COLOR-1:0]   i_solid;
  logic [3*BITS_PER_COLOR-1:0]   o_pixel;
  logic [2:0]                    o_mode;
  logic                          o_overrun;
  logic [15:0]                   o_frame_count;

  modport master (
    output i_rd, i_newline, i_newframe, i_mode, i_solid,
    input  o_pixel, o_mode, o_overrun, o_frame_count
  );

  modport slave (
    input  i_rd, i_newline, i_newframe, i_mode, i_solid,
    output o_pixel, o_mode, o_overrun, o_frame_count
  );
endinterface

// File: rtl/video_pos_counter.sv
// x/y position tracking with strobe priority (newframe > newline > rd),
// saturation at the active-area edge, sticky overrun flag and a bar
// sub-counter so the bar index needs no divider. Next-state values are
// exported so the top can register the pixel for the new position.
module video_pos_counter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int BAR_W    = 80,
  parameter int SUB_W    = 7
) (
  input  logic             clk_25mhz,
  input  logic             reset,
  input  logic             i_rd,
  input  logic             i_newline,
  input  logic             i_newframe,
  input  logic [SUB_W-1:0] i_pre_sub,
  input  logic [2:0]       i_pre_bar,
  output logic [X_W-1:0]   o_x_nxt,
  output logic [Y_W-1:0]   o_y_nxt,
  output logic [2:0]       o_bar_nxt,
  output logic             o_overrun
);

  logic [X_W-1:0]   r_x, w_x_nxt;
  logic [Y_W-1:0]   r_y, w_y_nxt;
  logic [SUB_W-1:0] r_sub, w_sub_nxt;
  logic [2:0]       r_bar, w_bar_nxt;
  logic             r_overrun, w_overrun_nxt;

  // Next position from the highest-priority strobe; lower ones are ignored
  always_comb begin
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_sub_nxt     = r_sub;
    w_bar_nxt     = r_bar;
    w_overrun_nxt = r_overrun;
    if (i_newframe) begin
      w_x_nxt       = '0;
      w_y_nxt       = '0;
      w_sub_nxt     = i_pre_sub;
      w_bar_nxt     = i_pre_bar;
      w_overrun_nxt = 1'b0;
    end else if (i_newline) begin
      w_x_nxt   = '0;
      w_sub_nxt = i_pre_sub;
      w_bar_nxt = i_pre_bar;
      if (r_y == Y_W'(V_ACTIVE - 1)) begin
        w_overrun_nxt = 1'b1;
      end else begin
        w_y_nxt = r_y + Y_W'(1);
      end
    end else if (i_rd) begin
      if (r_x == X_W'(H_ACTIVE - 1)) begin
        w_overrun_nxt = 1'b1;
      end else begin
        w_x_nxt = r_x + X_W'(1);
        if (r_sub == SUB_W'(BAR_W - 1)) begin
          w_sub_nxt = '0;
          w_bar_nxt = r_bar + 3'd1;
        end else begin
          w_sub_nxt = r_sub + SUB_W'(1);
        end
      end
    end
  end

  // Position registers, synchronous reset to the top-left corner
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_sub     <= '0;
      r_bar     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_sub     <= w_sub_nxt;
      r_bar     <= w_bar_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign o_x_nxt   = w_x_nxt;
  assign o_y_nxt   = w_y_nxt;
  assign o_bar_nxt = w_bar_nxt;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/video_pattern_gen.sv
// Parametrised test-pattern source for the HDMI encoder pixel-pull port.
// Optional scrolling and frame counter: define PATTERN_SCROLL_EN.
// The pixel is registered from the next-state position so o_pixel always
// matches the current (x,y) with no bubbles under back-to-back i_rd.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int BITS_PER_COLOR = 8,
  parameter int CHECK_LOG2     = 5,
  parameter int GRAD_SHIFT     = 2
) (
  input logic                clk_25mhz,
  input logic                reset,
  video_pattern_gen_if.slave bus
);

  localparam int X_W   = $clog2(H_ACTIVE);
  localparam int XS_W  = X_W + 1;
  localparam int Y_W   = $clog2(V_ACTIVE);
  localparam int BAR_W = bar_w(H_ACTIVE);
  localparam int SUB_W = $clog2(BAR_W);
  localparam int PIX_W = 3 * BITS_PER_COLOR;

  function automatic logic [PIX_W-1:0] expand_rgb(input logic [2:0] m);
    return {{BITS_PER_COLOR{m[2]}}, {BITS_PER_COLOR{m[1]}}, {BITS_PER_COLOR{m[0]}}};
  endfunction

  logic [X_W-1:0]            w_x_nxt, w_xs;
  logic [Y_W-1:0]            w_y_nxt;
  logic [2:0]                w_bar_nxt, w_pre_bar;
  logic [SUB_W-1:0]          w_pre_sub;
  logic [2:0]                r_mode, w_mode_nxt;
  logic [PIX_W-1:0]          r_pixel, w_pixel_nxt;
  logic [BITS_PER_COLOR-1:0] w_grad;
  logic                      w_border;

  video_pos_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .X_W      (X_W),
    .Y_W      (Y_W),
    .BAR_W    (BAR_W),
    .SUB_W    (SUB_W)
  ) u_pos (
    .clk_25mhz  (clk_25mhz),
    .reset      (reset),
    .i_rd       (bus.i_rd),
    .i_newline  (bus.i_newline),
    .i_newframe (bus.i_newframe),
    .i_pre_sub  (w_pre_sub),
    .i_pre_bar  (w_pre_bar),
    .o_x_nxt    (w_x_nxt),
    .o_y_nxt    (w_y_nxt),
    .o_bar_nxt  (w_bar_nxt),
    .o_overrun  (bus.o_overrun)
  );

`ifdef PATTERN_SCROLL_EN
  logic [15:0]      r_frame_count;
  logic [X_W-1:0]   r_off, w_off_nxt;
  logic [SUB_W-1:0] r_off_sub, w_off_sub_nxt;
  logic [2:0]       r_off_bar, w_off_bar_nxt;
  logic [XS_W-1:0]  w_xs_sum;

  // Scroll offset advances one pixel per frame, kept both as x mod H_ACTIVE
  // and as (bar, sub) so line-start preloads need no division
  always_comb begin
    w_off_nxt     = r_off;
    w_off_sub_nxt = r_off_sub;
    w_off_bar_nxt = r_off_bar;
    if (bus.i_newframe) begin
      w_off_nxt = (r_off == X_W'(H_ACTIVE - 1)) ? '0 : r_off + X_W'(1);
      if (r_off_sub == SUB_W'(BAR_W - 1)) begin
        w_off_sub_nxt = '0;
        w_off_bar_nxt = r_off_bar + 3'd1;
      end else begin
        w_off_sub_nxt = r_off_sub + SUB_W'(1);
      end
    end
  end

  // Frame counter and scroll offset registers
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_frame_count <= '0;
      r_off         <= '0;
      r_off_sub     <= '0;
      r_off_bar     <= '0;
    end else begin
      if (bus.i_newframe) r_frame_count <= r_frame_count + 16'd1;
      r_off     <= w_off_nxt;
      r_off_sub <= w_off_sub_nxt;
      r_off_bar <= w_off_bar_nxt;
    end
  end

  assign w_xs_sum  = {1'b0, w_x_nxt} + {1'b0, w_off_nxt};
  assign w_xs      = (w_xs_sum >= XS_W'(H_ACTIVE)) ? X_W'(w_xs_sum - XS_W'(H_ACTIVE))
                                                    : X_W'(w_xs_sum);
  assign w_pre_sub = w_off_sub_nxt;
  assign w_pre_bar = w_off_bar_nxt;
  assign bus.o_frame_count = r_frame_count;
`else
  assign w_xs      = w_x_nxt;
  assign w_pre_sub = '0;
  assign w_pre_bar = '0;
  assign bus.o_frame_count = '0;
`endif

  assign w_mode_nxt = bus.i_newframe ? bus.i_mode : r_mode;
  assign w_grad     = BITS_PER_COLOR'(w_x_nxt >> GRAD_SHIFT);
  assign w_border   = (w_x_nxt == '0) || (w_x_nxt == X_W'(H_ACTIVE - 1)) ||
                      (w_y_nxt == '0) || (w_y_nxt == Y_W'(V_ACTIVE - 1));

  // Pattern select for the position the counters are moving to
  always_comb begin
    w_pixel_nxt = '0;
    case (w_mode_nxt)
      MODE_BARS:   w_pixel_nxt = expand_rgb(bar_mask(w_bar_nxt));
      MODE_GRAD:   w_pixel_nxt = {3{w_grad}};
      MODE_CHECK:  w_pixel_nxt = (w_xs[CHECK_LOG2] ^ w_y_nxt[CHECK_LOG2]) ? '1 : '0;
      MODE_SOLID:  w_pixel_nxt = bus.i_solid;
      MODE_BORDER: w_pixel_nxt = w_border ? '1 : '0;
      default:     w_pixel_nxt = '0;
    endcase
  end

  // Output pixel and latched mode; reset shows bar 0 at the origin
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_mode  <= 3'(MODE_BARS);
      r_pixel <= expand_rgb(bar_mask(3'd0));
    end else begin
      r_mode  <= w_mode_nxt;
      r_pixel <= w_pixel_nxt;
    end
  end

  assign bus.o_pixel = r_pixel;
  assign bus.o_mode  = r_mode;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen: directed scenarios plus random
// strobes, checked every cycle against a behavioural pixel/position model.
module tb_video_pattern_gen;

  localparam int H = 640;
  localparam int V = 480;
`ifdef PATTERN_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic clk_25mhz = 1'b0;
  logic reset     = 1'b1;

  video_pattern_gen_if #(.BITS_PER_COLOR(8)) vif ();

  video_pattern_gen #(
    .H_ACTIVE       (H),
    .V_ACTIVE       (V),
    .BITS_PER_COLOR (8),
    .CHECK_LOG2     (5),
    .GRAD_SHIFT     (2)
  ) dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .bus       (vif)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 1'b0;
  int          m_x, m_y, m_mode, m_fc;
  bit          m_ovr;
  logic [23:0] m_pix;
  int          g_mode;
  logic [23:0] g_solid;
  logic [23:0] bar_tab [8];

  function automatic logic [23:0] ref_pixel(int x, int y, int mode, int fc, logic [23:0] solid);
    int xs;
    int g;
    xs = SCROLL ? (x + fc) % H : x;
    g  = (x >> 2) & 255;
    case (mode)
      0: return bar_tab[xs / (H / 8)];
      1: return {g[7:0], g[7:0], g[7:0]};
      2: return ((((xs >> 5) & 1) ^ ((y >> 5) & 1)) != 0) ? 24'hFFFFFF : 24'h000000;
      3: return solid;
      4: return (x == 0 || x == H - 1 || y == 0 || y == V - 1) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, and land 1ns after the next negedge
  task automatic tick(bit rst, bit nf, bit nl, bit rd, int mode, logic [23:0] solid);
    reset          = rst;
    vif.i_newframe = nf;
    vif.i_newline  = nl;
    vif.i_rd       = rd;
    vif.i_mode     = mode[2:0];
    vif.i_solid    = solid;
    if (rst) begin
      m_x = 0; m_y = 0; m_mode = 0; m_ovr = 1'b0; m_fc = 0;
    end else if (nf) begin
      m_x = 0; m_y = 0; m_mode = mode & 7; m_ovr = 1'b0; m_fc = (m_fc + 1) % 65536;
    end else if (nl) begin
      m_x = 0;
      if (m_y == V - 1) m_ovr = 1'b1;
      else m_y++;
    end else if (rd) begin
      if (m_x == H - 1) m_ovr = 1'b1;
      else m_x++;
    end
    m_pix = ref_pixel(m_x, m_y, m_mode, m_fc, solid);
    @(negedge clk_25mhz);
    #1;
  endtask

  task automatic rds(int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 1, g_mode, g_solid);
  endtask

  task automatic newlines(int n);
    for (int i = 0; i < n; i++) tick(0, 0, 1, 0, g_mode, g_solid);
  endtask

  task automatic newframe();
    tick(0, 1, 0, 0, g_mode, g_solid);
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk_25mhz) begin
    if (chk_en) begin
      chk("pixel", 32'(vif.o_pixel), 32'(m_pix));
      chk("mode", 32'(vif.o_mode), 32'(m_mode));
      chk("overrun", 32'(vif.o_overrun), 32'(m_ovr));
      chk("frame_count", 32'(vif.o_frame_count), SCROLL ? 32'(m_fc) : 32'd0);
    end
  end

  initial begin
    bar_tab = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    vif.i_rd = 1'b0; vif.i_newline = 1'b0; vif.i_newframe = 1'b0;
    vif.i_mode = 3'd0; vif.i_solid = 24'd0;
    g_mode = 0; g_solid = 24'd0;
    m_x = 0; m_y = 0; m_mode = 0; m_fc = 0; m_ovr = 1'b0; m_pix = 24'hFFFFFF;
    @(negedge clk_25mhz);
    #1;

    tick(1, 0, 0, 0, 0, 24'd0);
    chk_en = 1'b1;
    tick(1, 0, 0, 0, 0, 24'd0);
    chk("rst_pixel", 32'(vif.o_pixel), 32'hFFFFFF);
    chk("rst_mode", 32'(vif.o_mode), 32'd0);
    chk("rst_overrun", 32'(vif.o_overrun), 32'd0);
    chk("rst_frame_count", 32'(vif.o_frame_count), 32'd0);

    // colour bars across a full line
    g_mode = 0; newframe();
    chk("bars_x0", 32'(vif.o_pixel), 32'hFFFFFF);
    rds(100);
    chk("bars_x100", 32'(vif.o_pixel), 32'hFFFF00);
    rds(500);
    chk("bars_x600", 32'(vif.o_pixel), 32'h000000);
    rds(39);
    chk("bars_x639_no_ovr", 32'(vif.o_overrun), 32'd0);
    rds(1);
    chk("x_sat_ovr", 32'(vif.o_overrun), 32'd1);

    // grey gradient
    g_mode = 1; newframe();
    chk("ovr_cleared", 32'(vif.o_overrun), 32'd0);
    rds(4);
    chk("grad_x4", 32'(vif.o_pixel), 32'h010101);
    rds(632);
    chk("grad_x636", 32'(vif.o_pixel), 32'h9F9F9F);

    // checkerboard
    g_mode = 2; newframe();
    rds(32);
    chk("check_32_0", 32'(vif.o_pixel), 32'hFFFFFF);
    newlines(32);
    rds(32);
    chk("check_32_32", 32'(vif.o_pixel), 32'h000000);

    // solid, mode change without newframe is ignored
    g_mode = 3; g_solid = 24'h123456; newframe();
    chk("solid", 32'(vif.o_pixel), 32'h123456);
    g_mode = 0; rds(50);
    chk("solid_held", 32'(vif.o_pixel), 32'h123456);
    chk("solid_mode_held", 32'(vif.o_mode), 32'd3);
    newframe();
    chk("bars_after_nf", 32'(vif.o_pixel), 32'hFFFFFF);
    chk("mode_after_nf", 32'(vif.o_mode), 32'd0);

    // border and y saturation
    g_mode = 4; newframe();
    rds(5); newlines(5); rds(5);
    chk("border_inner", 32'(vif.o_pixel), 32'h000000);
    newlines(474);
    chk("y479_no_ovr", 32'(vif.o_overrun), 32'd0);
    chk("border_bottom", 32'(vif.o_pixel), 32'hFFFFFF);
    newlines(1);
    chk("y_sat_ovr", 32'(vif.o_overrun), 32'd1);
    newframe();
    chk("y_ovr_cleared", 32'(vif.o_overrun), 32'd0);

    // priority: newline beats rd at the line end, newframe beats both
    g_mode = 0; newframe();
    rds(639);
    tick(0, 0, 1, 1, g_mode, g_solid);
    chk("nl_rd_no_ovr", 32'(vif.o_overrun), 32'd0);
    chk("nl_rd_x0", 32'(vif.o_pixel), 32'hFFFFFF);
    rds(640);
    chk("ovr_before_all3", 32'(vif.o_overrun), 32'd1);
    tick(0, 1, 1, 1, g_mode, g_solid);
    chk("all3_ovr", 32'(vif.o_overrun), 32'd0);
    chk("all3_pixel", 32'(vif.o_pixel), 32'hFFFFFF);

    // bar boundary after three frames (scrolls by the frame count when enabled)
    tick(1, 0, 0, 0, 0, 24'd0);
    g_mode = 0; newframe(); newframe(); newframe();
    chk("fc_after3", 32'(vif.o_frame_count), SCROLL ? 32'd3 : 32'd0);
    rds(76);
    chk("bar_x76", 32'(vif.o_pixel), 32'hFFFFFF);
    rds(1);
    chk("bar_x77", 32'(vif.o_pixel), SCROLL ? 32'hFFFF00 : 32'hFFFFFF);
    rds(3);
    chk("bar_x80", 32'(vif.o_pixel), 32'hFFFF00);

    // random strobes, modes, colours and occasional mid-frame reset
    for (int i = 0; i < 6000; i++) begin
      bit r_rst, r_nf, r_nl, r_rd;
      r_rst = ($urandom % 1500) == 0;
      r_nf  = ($urandom % 150) == 0;
      r_nl  = ($urandom % 25) == 0;
      r_rd  = ($urandom % 5) != 0;
      if (($urandom % 40) == 0) g_mode = int'($urandom % 8);
      g_solid = 24'($urandom);
      tick(r_rst, r_nf, r_nl, r_rd, g_mode, g_solid);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
